// File: rtl/rv32i_mem_pkg.sv
// Shared types and default widths for the rv32i IF/LS memory arbiter.
package rv32i_mem_pkg;
  localparam int DEF_ADDR_W = 32;
  localparam int DEF_DATA_W = 32;

  typedef enum logic {ST_IDLE = 1'b0, ST_BUSY = 1'b1} state_e;
  typedef enum logic {OWN_IF  = 1'b0, OWN_LS  = 1'b1} owner_e;
endpackage

// File: rtl/rv32i_prio_sel.sv
// Two-way fixed-priority select: LS beats IF unless IF has been starved.
module rv32i_prio_sel (
  input  logic if_req,
  input  logic ls_req,
  input  logic starve_hit,
  output logic gnt_if,
  output logic gnt_ls
);
  logic w_if_override;

  assign w_if_override = starve_hit & if_req;
  assign gnt_ls        = ls_req & ~w_if_override;
  assign gnt_if        = if_req & (~ls_req | starve_hit);
endmodule

// File: rtl/rv32i_mem_arbiter.sv
// Single-port memory arbiter between the rv32i fetch (IF) and load/store (LS)
// ports: one outstanding transaction, LS priority with an IF starvation guard.
module rv32i_mem_arbiter
  import rv32i_mem_pkg::*;
#(
  parameter int ADDR_W     = DEF_ADDR_W,
  parameter int DATA_W     = DEF_DATA_W,
  parameter int MEM_LAT    = 1,
  parameter int STARVE_MAX = 4
) (
  input  logic                clk,
  input  logic                reset_n,
  input  logic                if_req,
  input  logic [ADDR_W-1:0]   if_addr,
  output logic                if_gnt,
  output logic                if_rvalid,
  output logic [DATA_W-1:0]   if_rdata,
  input  logic                ls_req,
  input  logic                ls_we,
  input  logic [DATA_W/8-1:0] ls_be,
  input  logic [ADDR_W-1:0]   ls_addr,
  input  logic [DATA_W-1:0]   ls_wdata,
  output logic                ls_gnt,
  output logic                ls_rvalid,
  output logic [DATA_W-1:0]   ls_rdata,
  output logic                mem_en,
  output logic                mem_we,
  output logic [DATA_W/8-1:0] mem_be,
  output logic [ADDR_W-1:0]   mem_addr,
  output logic [DATA_W-1:0]   mem_wdata,
  input  logic [DATA_W-1:0]   mem_rdata
);
  localparam logic [2:0] LAT_INIT  = 3'(MEM_LAT - 1);
  localparam logic [3:0] STARVE_TH = 4'(STARVE_MAX);

  state_e     r_state,      w_state_nxt;
  owner_e     r_owner,      w_owner_nxt;
  logic [2:0] r_lat_cnt,    w_lat_cnt_nxt;
  logic [3:0] r_starve_cnt, w_starve_cnt_nxt;
  logic       r_owner_we,   w_owner_we_nxt;

  logic w_resp, w_window, w_starve_hit;

  // Grants are masked while reset is held so every output reads 0 immediately.
  assign w_resp       = (r_state == ST_BUSY) && (r_lat_cnt == 3'd0);
  assign w_window     = reset_n && ((r_state == ST_IDLE) || w_resp);
  assign w_starve_hit = (r_starve_cnt >= STARVE_TH);

  rv32i_prio_sel u_prio_sel (
    .if_req     (if_req & w_window),
    .ls_req     (ls_req & w_window),
    .starve_hit (w_starve_hit),
    .gnt_if     (if_gnt),
    .gnt_ls     (ls_gnt)
  );

  assign if_rvalid = w_resp && (r_owner == OWN_IF);
  assign ls_rvalid = w_resp && (r_owner == OWN_LS);
  assign if_rdata  = if_rvalid ? mem_rdata : '0;
  assign ls_rdata  = (ls_rvalid && !r_owner_we) ? mem_rdata : '0;

  always_comb begin
    mem_en    = 1'b0;
    mem_we    = 1'b0;
    mem_be    = '0;
    mem_addr  = '0;
    mem_wdata = '0;
    if (ls_gnt) begin
      mem_en    = 1'b1;
      mem_we    = ls_we;
      mem_be    = ls_be;
      mem_addr  = ls_addr;
      mem_wdata = ls_wdata;
    end else if (if_gnt) begin
      mem_en   = 1'b1;
      mem_addr = if_addr;
    end
  end

  always_comb begin
    w_state_nxt      = r_state;
    w_owner_nxt      = r_owner;
    w_lat_cnt_nxt    = r_lat_cnt;
    w_owner_we_nxt   = r_owner_we;
    w_starve_cnt_nxt = r_starve_cnt;
    if (if_gnt || ls_gnt) begin
      w_state_nxt    = ST_BUSY;
      w_owner_nxt    = ls_gnt ? OWN_LS : OWN_IF;
      w_owner_we_nxt = ls_gnt && ls_we;
      w_lat_cnt_nxt  = LAT_INIT;
    end else if (r_state == ST_BUSY && r_lat_cnt != 3'd0) begin
      w_lat_cnt_nxt = r_lat_cnt - 3'd1;
    end else if (w_resp) begin
      w_state_nxt = ST_IDLE;
    end
    // IF only accrues starvation when it actually lost a window to LS.
    if (if_gnt)
      w_starve_cnt_nxt = 4'd0;
    else if (w_window && if_req && ls_gnt && r_starve_cnt != 4'hF)
      w_starve_cnt_nxt = r_starve_cnt + 4'd1;
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_state      <= ST_IDLE;
      r_owner      <= OWN_IF;
      r_lat_cnt    <= 3'd0;
      r_starve_cnt <= 4'd0;
      r_owner_we   <= 1'b0;
    end else begin
      r_state      <= w_state_nxt;
      r_owner      <= w_owner_nxt;
      r_lat_cnt    <= w_lat_cnt_nxt;
      r_starve_cnt <= w_starve_cnt_nxt;
      r_owner_we   <= w_owner_we_nxt;
    end
  end
endmodule

// File: tb/tb_rv32i_mem_arbiter.sv
// Bench for rv32i_mem_arbiter: vector table on a MEM_LAT=1 instance, directed
// latency/reset sequences and a randomized reference-model run on MEM_LAT=3.
module tb_rv32i_mem_arbiter;
  typedef struct packed {
    logic        if_req;
    logic [31:0] if_addr;
    logic        ls_req;
    logic        ls_we;
    logic [3:0]  ls_be;
    logic [31:0] ls_addr;
    logic [31:0] ls_wdata;
  } req_t;

  typedef struct packed {
    logic        if_gnt;
    logic        if_rvalid;
    logic [31:0] if_rdata;
    logic        ls_gnt;
    logic        ls_rvalid;
    logic [31:0] ls_rdata;
    logic        mem_en;
    logic        mem_we;
    logic [3:0]  mem_be;
    logic [31:0] mem_addr;
    logic [31:0] mem_wdata;
  } rsp_t;

  typedef struct {
    string nm;
    req_t  in;
    rsp_t  exp;
  } vec_t;

  localparam int RW = $bits(rsp_t);
  localparam int LAT3 = 3;
  localparam int STARVE = 4;

  logic        clk = 1'b0;
  logic        reset_n = 1'b0;
  req_t        in1, in3;
  wire rsp_t   o1, o3;
  logic [31:0] rd1, rd3;
  int          n_chk = 0;
  int          n_fail = 0;

  always #5 clk = ~clk;

  // Preloaded memory: word at address a holds a*9+3; rdata holds until next access.
  function automatic logic [31:0] memf(input logic [31:0] a);
    return a * 32'd9 + 32'd3;
  endfunction

  always @(posedge clk) if (o1.mem_en) rd1 <= memf(o1.mem_addr);
  always @(posedge clk) if (o3.mem_en) rd3 <= memf(o3.mem_addr);

  rv32i_mem_arbiter #(.MEM_LAT(1), .STARVE_MAX(STARVE)) u_dut1 (
    .clk(clk), .reset_n(reset_n),
    .if_req(in1.if_req), .if_addr(in1.if_addr),
    .if_gnt(o1.if_gnt), .if_rvalid(o1.if_rvalid), .if_rdata(o1.if_rdata),
    .ls_req(in1.ls_req), .ls_we(in1.ls_we), .ls_be(in1.ls_be),
    .ls_addr(in1.ls_addr), .ls_wdata(in1.ls_wdata),
    .ls_gnt(o1.ls_gnt), .ls_rvalid(o1.ls_rvalid), .ls_rdata(o1.ls_rdata),
    .mem_en(o1.mem_en), .mem_we(o1.mem_we), .mem_be(o1.mem_be),
    .mem_addr(o1.mem_addr), .mem_wdata(o1.mem_wdata), .mem_rdata(rd1)
  );

  rv32i_mem_arbiter #(.MEM_LAT(LAT3), .STARVE_MAX(STARVE)) u_dut3 (
    .clk(clk), .reset_n(reset_n),
    .if_req(in3.if_req), .if_addr(in3.if_addr),
    .if_gnt(o3.if_gnt), .if_rvalid(o3.if_rvalid), .if_rdata(o3.if_rdata),
    .ls_req(in3.ls_req), .ls_we(in3.ls_we), .ls_be(in3.ls_be),
    .ls_addr(in3.ls_addr), .ls_wdata(in3.ls_wdata),
    .ls_gnt(o3.ls_gnt), .ls_rvalid(o3.ls_rvalid), .ls_rdata(o3.ls_rdata),
    .mem_en(o3.mem_en), .mem_we(o3.mem_we), .mem_be(o3.mem_be),
    .mem_addr(o3.mem_addr), .mem_wdata(o3.mem_wdata), .mem_rdata(rd3)
  );

  function automatic req_t rq(input logic ir, input logic [31:0] ia, input logic lr,
                              input logic lw, input logic [3:0] lb,
                              input logic [31:0] la, input logic [31:0] ld);
    return '{ir, ia, lr, lw, lb, la, ld};
  endfunction

  function automatic rsp_t rs(input logic ig, input logic iv, input logic [31:0] id,
                              input logic lg, input logic lv, input logic [31:0] ldat,
                              input logic me, input logic mw, input logic [3:0] mb,
                              input logic [31:0] ma, input logic [31:0] md);
    return '{ig, iv, id, lg, lv, ldat, me, mw, mb, ma, md};
  endfunction

  task automatic chk(input string nm, input logic [RW-1:0] act, input logic [RW-1:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", nm, act, exp);
    end
  endtask

  // Inputs change 1ns after the rising edge; outputs are sampled 1ns later.
  task automatic cyc();
    @(posedge clk);
    #1;
  endtask

  vec_t tbl[10];

  initial begin
    #1000000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1);
  end

  initial begin
    bit          outst, own_if, own_we, resp, win, gi, gl;
    int          due, starve;
    logic [31:0] own_addr;
    rsp_t        e;

    tbl[0] = '{"idle",        rq(0, 0, 0, 0, 0, 0, 0), rs(0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0)};
    tbl[1] = '{"if_fetch",    rq(1, 32'h10, 0, 0, 0, 0, 0),
                              rs(1, 0, 0, 0, 0, 0, 1, 0, 0, 32'h10, 0)};
    tbl[2] = '{"if_resp",     rq(0, 0, 0, 0, 0, 0, 0),
                              rs(0, 1, 32'h93, 0, 0, 0, 0, 0, 0, 0, 0)};
    tbl[3] = '{"ls_over_if",  rq(1, 32'h14, 1, 0, 4'hF, 32'h100, 32'h55),
                              rs(0, 0, 0, 1, 0, 0, 1, 0, 4'hF, 32'h100, 32'h55)};
    tbl[4] = '{"ls_resp_b2b", rq(1, 32'h14, 0, 0, 0, 0, 0),
                              rs(1, 0, 0, 0, 1, 32'h903, 1, 0, 0, 32'h14, 0)};
    tbl[5] = '{"store_issue", rq(0, 0, 1, 1, 4'b0011, 32'h200, 32'hDEADBEEF),
                              rs(0, 1, 32'hB7, 1, 0, 0, 1, 1, 4'b0011, 32'h200, 32'hDEADBEEF)};
    tbl[6] = '{"store_ack",   rq(0, 0, 0, 0, 0, 0, 0),
                              rs(0, 0, 0, 0, 1, 0, 0, 0, 0, 0, 0)};
    tbl[7] = '{"idle2",       rq(0, 0, 0, 0, 0, 0, 0), rs(0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0)};
    tbl[8] = '{"load_zero",   rq(0, 0, 1, 0, 0, 0, 0),
                              rs(0, 0, 0, 1, 0, 0, 1, 0, 0, 0, 0)};
    tbl[9] = '{"load_resp",   rq(0, 0, 0, 0, 0, 0, 0),
                              rs(0, 0, 0, 0, 1, 32'h3, 0, 0, 0, 0, 0)};

    // Reset with requests pending: every output must be 0.
    in1 = rq(1, 32'h10, 1, 1, 4'hF, 32'h20, 32'h1);
    in3 = in1;
    #12;
    chk("reset_dut1", o1, '0);
    chk("reset_dut3", o3, '0);
    in1 = '0;
    in3 = '0;
    @(negedge clk) reset_n = 1'b1;

    for (int i = 0; i < 10; i++) begin
      cyc();
      in1 = tbl[i].in;
      #1 chk(tbl[i].nm, o1, tbl[i].exp);
    end
    cyc();
    in1 = '0;

    // LS held continuously with IF: IF wins every 5th window, then the guard restarts.
    for (int w = 0; w < 10; w++) begin
      cyc();
      in1 = rq(1, 32'h40, 1, 0, 4'hF, 32'h300, 0);
      #1 chk($sformatf("starve_w%0d", w), RW'({o1.if_gnt, o1.ls_gnt}),
             RW'({w % 5 == 4, w % 5 != 4}));
    end
    cyc();
    in1 = '0;
    cyc();

    // MEM_LAT=3: IF owns the memory, a pending LS waits for the response cycle.
    cyc(); in3 = rq(1, 32'h20, 0, 0, 0, 0, 0);
    #1 chk("lat3_if_gnt", o3, rs(1, 0, 0, 0, 0, 0, 1, 0, 0, 32'h20, 0));
    cyc(); in3 = rq(0, 0, 1, 0, 4'hF, 32'h100, 0);
    #1 chk("lat3_wait1", o3, '0);
    cyc();
    #1 chk("lat3_wait2", o3, '0);
    cyc();
    #1 chk("lat3_resp_gnt", o3, rs(0, 1, 32'h123, 1, 0, 0, 1, 0, 4'hF, 32'h100, 0));
    cyc(); in3 = '0;
    #1 chk("lat3_ls_wait1", o3, '0);
    cyc();
    #1 chk("lat3_ls_wait2", o3, '0);
    cyc();
    #1 chk("lat3_ls_resp", o3, rs(0, 0, 0, 0, 1, 32'h903, 0, 0, 0, 0, 0));
    cyc();
    #1 chk("lat3_idle", o3, '0);

    // Reset asserted one cycle into a MEM_LAT=3 read.
    cyc(); in3 = rq(1, 32'h40, 0, 0, 0, 0, 0);
    #1 chk("rst_if_gnt", o3, rs(1, 0, 0, 0, 0, 0, 1, 0, 0, 32'h40, 0));
    cyc(); in3 = rq(0, 0, 1, 0, 0, 32'h60, 0);
    in1 = rq(1, 32'h44, 0, 0, 0, 0, 0);
    reset_n = 1'b0;
    #1 chk("rst_mid_dut3", o3, '0);
    chk("rst_mid_dut1", o1, '0);
    cyc();
    #1 chk("rst_held_dut3", o3, '0);
    in1 = '0;
    in3 = '0;
    reset_n = 1'b1;
    for (int k = 0; k < 4; k++) begin
      cyc();
      #1 chk($sformatf("rst_quiet%0d", k), o3, '0);
    end
    cyc(); in3 = rq(0, 0, 1, 0, 0, 32'h60, 0);
    #1 chk("rst_first_gnt", o3, rs(0, 0, 0, 1, 0, 0, 1, 0, 0, 32'h60, 0));
    cyc(); in3 = '0;
    cyc();
    cyc();
    #1 chk("rst_first_resp", o3, rs(0, 0, 0, 0, 1, 32'h363, 0, 0, 0, 0, 0));
    cyc();

    // Randomized run on MEM_LAT=3 against a transaction-level model.
    outst = 0; own_if = 0; own_we = 0; own_addr = '0; due = 0; starve = 0;
    for (int k = 0; k < 400; k++) begin
      cyc();
      in3.if_req   = ($urandom_range(0, 9) < 7);
      in3.if_addr  = $urandom;
      in3.ls_req   = ($urandom_range(0, 9) < 6);
      in3.ls_we    = $urandom_range(0, 1);
      in3.ls_be    = 4'($urandom);
      in3.ls_addr  = $urandom;
      in3.ls_wdata = $urandom;
      #1;
      e    = '0;
      resp = outst && (due == k);
      win  = !outst || resp;
      if (resp) begin
        if (own_if) begin
          e.if_rvalid = 1'b1;
          e.if_rdata  = memf(own_addr);
        end else begin
          e.ls_rvalid = 1'b1;
          e.ls_rdata  = own_we ? 32'h0 : memf(own_addr);
        end
      end
      gi = win && in3.if_req && (!in3.ls_req || starve >= STARVE);
      gl = win && in3.ls_req && !gi;
      if (gl) begin
        e.ls_gnt = 1'b1; e.mem_en = 1'b1; e.mem_we = in3.ls_we; e.mem_be = in3.ls_be;
        e.mem_addr = in3.ls_addr; e.mem_wdata = in3.ls_wdata;
      end else if (gi) begin
        e.if_gnt = 1'b1; e.mem_en = 1'b1; e.mem_addr = in3.if_addr;
      end
      chk($sformatf("rand_c%0d", k), o3, e);
      if (resp) outst = 0;
      if (gi || gl) begin
        outst    = 1;
        due      = k + LAT3;
        own_if   = gi;
        own_we   = gl && in3.ls_we;
        own_addr = gi ? in3.if_addr : in3.ls_addr;
      end
      if (gi) starve = 0;
      else if (win && in3.if_req && gl && starve < 15) starve++;
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end
endmodule

// File: doc/rv32i_mem_arbiter.md
Name: rv32i_mem_arbiter

Overview:
- Shares one single-port unified memory between the rv32i_core instruction-fetch port (IF) and the load/store port (LS).
- Grants one transaction at a time under fixed LS-over-IF priority, with a starvation guard for IF.
- Sequences memory latency and returns read data or a write acknowledge to the winner.
- Sits between the core and the memory model that the core testbench preloads.

Parameters:
ADDR_W, 32, address width
DATA_W, 32, data width
MEM_LAT, 1, cycles from mem_en to mem_rdata valid (range 1..8)
STARVE_MAX, 4, consecutive IF-denied cycles before IF is given priority (range 1..15)

Ports:
clk  in  1  clock, rising edge
reset_n  in  1  asynchronous active-low reset
if_req  in  1  fetch request, held until if_gnt
if_addr  in  ADDR_W  fetch address
if_gnt  out  1  fetch accepted this cycle
if_rvalid  out  1  fetch data valid, 1-cycle pulse
if_rdata  out  DATA_W  fetch data
ls_req  in  1  load/store request, held until ls_gnt
ls_we  in  1  1 = store
ls_be  in  DATA_W/8  byte enables for a store
ls_addr  in  ADDR_W  load/store address
ls_wdata  in  DATA_W  store data
ls_gnt  out  1  load/store accepted this cycle
ls_rvalid  out  1  load data valid or store ack, 1-cycle pulse
ls_rdata  out  DATA_W  load data
mem_en  out  1  memory access strobe
mem_we  out  1  memory write
mem_be  out  DATA_W/8  memory byte enables
mem_addr  out  ADDR_W  memory address
mem_wdata  out  DATA_W  memory write data
mem_rdata  in  DATA_W  memory read data, valid MEM_LAT cycles after mem_en

Behaviour:
- States: IDLE and BUSY. Registers:
  - owner (IF or LS)
  - lat_cnt (3 bits)
  - starve_cnt (4 bits)
  - owner_we
- Arbitration window:
  - The window is open when state==IDLE, or when state==BUSY && lat_cnt==0 (the response cycle).
  - Back-to-back issue therefore gives one transaction per MEM_LAT cycles.
- Winner selection in an open window:
  - Default: LS wins if ls_req, else IF if if_req.
  - If starve_cnt>=STARVE_MAX and if_req, IF wins even when ls_req=1.
- Grant cycle behaviour (combinational from state and reqs):
  - Winner's gnt=1.
  - mem_en=1; mem_addr, mem_we, mem_be, mem_wdata are taken from the winner.
  - mem_we=0 and mem_be=0 for an IF grant.
- Register updates on grant:
  - owner <= winner; owner_we <= winner is LS && ls_we.
  - lat_cnt <= MEM_LAT-1; state <= BUSY.
- BUSY with lat_cnt>0: lat_cnt decrements; no grant; mem_en=0.
- Response cycle (BUSY && lat_cnt==0):
  - The owner's rvalid=1.
  - if_rdata = mem_rdata for an IF owner; ls_rdata = mem_rdata for an LS load; ls_rdata = 0 for a store ack.
  - A new grant may issue in the same cycle. With no grant, state <= IDLE.
- Idle output values:
  - rdata outputs are 0 whenever their rvalid=0.
  - mem_addr, mem_wdata, mem_be, mem_we are 0 when mem_en=0.
- Starvation counter:
  - Increments (saturating at 15) in every open-window cycle where if_req=1 and LS wins.
  - Clears to 0 when IF is granted.
  - Holds otherwise.
- Simultaneous if_req and ls_req: LS wins unless the starvation rule applies. The loser's gnt=0, and it must hold its request.
- Request dropped before gnt: legal; no transaction issues.
- Reset:
  - Asynchronous, active-low; effective immediately, including mid-transaction.
  - state=IDLE; lat_cnt=0; starve_cnt=0; owner=IF; owner_we=0.
  - All outputs 0. An in-flight response is discarded (no rvalid after reset release).
- Only one transaction is ever outstanding, so rvalid on IF and LS is never asserted in the same cycle.

Decomposition:
- Shared package rv32i_mem_pkg:
  - Owner encoding OWN_IF=1'b0, OWN_LS=1'b1.
  - State encoding ST_IDLE/ST_BUSY.
  - Default widths ADDR_W/DATA_W.
- One sub-module is natural: rv32i_prio_sel. It is the combinational 2-way priority select with the starvation override, with inputs if_req, ls_req, starve_hit and outputs gnt_if, gnt_ls.
- The FSM, counters and muxes stay in the top module.

Test Plan:
- MEM_LAT=1, if_req only, if_addr=0x0000_0010 with mem_rdata=0x0000_0093 -> if_gnt at T, mem_en=1, mem_addr=0x10 at T; if_rvalid=1, if_rdata=0x93 at T+1.
- Both reqs at T, ls_we=0, ls_addr=0x100 -> ls_gnt at T, if_gnt=0; at T+1, ls_rvalid with mem_rdata and if_gnt=1 (back-to-back).
- ls_req held high continuously plus if_req, STARVE_MAX=4 -> LS granted 4 times, IF granted in the 5th window; starve_cnt returns to 0.
- Store ls_we=1, ls_be=4'b0011, ls_wdata=0xDEAD_BEEF, addr=0x200 -> mem_we=1, mem_be=0011, mem_wdata=0xDEADBEEF at T; ls_rvalid=1, ls_rdata=0 at T+1.
- MEM_LAT=3, IF request at T -> no grant at T+1/T+2 for a pending ls_req; if_rvalid at T+3, ls_gnt at T+3.
- reset_n driven low at T+1 of an MEM_LAT=3 read -> all outputs 0 immediately; no rvalid after release; first request after release granted normally.
